// File: rtl/pipe_drain_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pipe_drain_buffer
// Purpose  : Credit-guarded drain FIFO at the tail of a fixed-latency pipe.
//            Optional error detection: PIPE_DRAIN_BUFFER_ERR_CHECK_EN.
// Revision : 1.0
// ============================================================================
module pipe_drain_buffer #(
  parameter int BITWIDTH = 8,
  parameter int DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic                     in_valid,
  input  logic [BITWIDTH-1:0]      in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BITWIDTH-1:0]      out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
      $error("pipe_drain_buffer: DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [BITWIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_level;
  logic [CW-1:0]       r_inflight;

  logic                w_issue;
  logic                w_pop;
  logic                w_full;
  logic                w_store;
  logic [CW:0]         w_credit;

  // Credit check uses one extra bit so level + inflight cannot wrap.
  assign w_credit    = {1'b0, r_level} + {1'b0, r_inflight};
  assign issue_ready = (w_credit < {1'b0, C_DEPTH});
  assign w_issue     = issue_valid && issue_ready;
  assign out_valid   = (r_level != '0);
  assign w_pop       = out_valid && out_ready;
  assign w_full      = (r_level == C_DEPTH);
  assign w_store     = in_valid && (!w_full || w_pop);
  assign out_data    = r_mem[r_rd_ptr];
  assign level       = r_level;

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_inflight <= '0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_store, w_pop})
        2'b10:   r_level <= r_level + CW'(1);
        2'b01:   r_level <= r_level - CW'(1);
        default: r_level <= r_level;
      endcase
      // An orphan push (nothing in flight) leaves the counter pinned at zero.
      if (w_issue && !in_valid) begin
        r_inflight <= r_inflight + CW'(1);
      end else if (!w_issue && in_valid && (r_inflight != '0)) begin
        r_inflight <= r_inflight - CW'(1);
      end
    end
  end

`ifdef PIPE_DRAIN_BUFFER_ERR_CHECK_EN
  logic r_err;
  logic w_err_event;

  assign w_err_event = in_valid && ((w_full && !w_pop) || (r_inflight == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_err_event) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_drain_buffer.sv
`default_nettype none
// Directed self-checking bench for pipe_drain_buffer (DEPTH=8, BITWIDTH=8).
module tb_pipe_drain_buffer;

`ifdef PIPE_DRAIN_BUFFER_ERR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       issue_valid;
  logic       issue_ready;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] level;
  logic       err;

  int n_vec;
  int n_err;

  pipe_drain_buffer #(.BITWIDTH(8), .DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst         = 1'b1;
    issue_valid = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    out_ready   = 1'b0;

    // Reset, with a push attempted while rst is held.
    cyc();
    in_valid = 1'b1;
    in_data  = 8'hEE;
    cyc();
    in_valid = 1'b0;
    chk("rst_level", level, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_err", err, 0);
    #2;
    rst = 1'b0;
    cyc();

    // Fill: 8 issues, results arrive 4 cycles later, no consumer.
    for (int c = 0; c < 12; c++) begin
      issue_valid = (c < 8);
      in_valid    = (c >= 4);
      in_data     = 8'(c) - 8'd4;
      chk("fill_issue_ready", issue_ready, (c < 8) ? 1 : 0);
      cyc();
    end
    issue_valid = 1'b0;
    in_valid    = 1'b0;
    chk("fill_level", level, 8);
    chk("fill_out_valid", out_valid, 1);
    chk("fill_issue_ready_end", issue_ready, 0);
    chk("fill_err", err, 0);
    chk("fill_head", out_data, 8'h00);

    // Drain in order.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", out_data, i);
      cyc();
    end
    out_ready = 1'b0;
    chk("drain_level", level, 0);
    chk("drain_out_valid", out_valid, 0);
    chk("drain_issue_ready", issue_ready, 1);

    // Streaming: issue/push/pop every cycle, pipe latency 1, level 1 steady.
    for (int c = 0; c < 30; c++) begin
      issue_valid = (c < 28);
      in_valid    = (c >= 1) && (c < 29);
      in_data     = 8'h40 + 8'(c) - 8'd1;
      out_ready   = (c >= 2);
      if (c >= 2) begin
        chk("stream_valid", out_valid, 1);
        chk("stream_data", out_data, 32'h40 + c - 2);
        chk("stream_ready", issue_ready, 1);
      end
      cyc();
      if (c >= 2 && c <= 27) chk("stream_level", level, 1);
    end
    issue_valid = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    chk("stream_end_level", level, 0);
    chk("stream_end_ready", issue_ready, 1);
    chk("stream_err", err, 0);

    // Overflow: fill legally, then force an extra word.
    issue_valid = 1'b1;
    repeat (8) cyc();
    issue_valid = 1'b0;
    chk("ovf_ready_full_credit", issue_ready, 0);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h10 + 8'(i);
      cyc();
    end
    chk("ovf_level_before", level, 8);
    chk("ovf_err_before", err, 0);
    in_data = 8'hAA;
    cyc();
    in_valid = 1'b0;
    chk("ovf_level", level, 8);
    chk("ovf_head", out_data, 8'h10);
    chk("ovf_err", err, EXP_ERR);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain_data", out_data, 32'h10 + i);
      cyc();
    end
    // Pop request while empty must be ignored.
    cyc();
    out_ready = 1'b0;
    chk("ovf_empty_level", level, 0);
    chk("ovf_err_sticky", err, EXP_ERR);

    // Reset mid-operation: level 5, inflight 3.
    issue_valid = 1'b1;
    repeat (8) cyc();
    issue_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h30 + 8'(i);
      cyc();
    end
    in_valid = 1'b0;
    chk("mid_level", level, 5);
    chk("mid_ready", issue_ready, 0);
    chk("mid_head", out_data, 8'h30);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_ready", issue_ready, 1);
    chk("arst_err", err, 0);
    #1;
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h77;
    cyc();
    in_valid = 1'b0;
    chk("late_level", level, 1);
    chk("late_valid", out_valid, 1);
    chk("late_data", out_data, 8'h77);
    chk("late_err", err, EXP_ERR);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_drain_buffer.md
PIPE_DRAIN_BUFFER -- requirements
Module: pipe_drain_buffer

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8: width of the data word.
REQ-002 SHALL have parameter DEPTH, default 8: buffer entries; a power of two, at least 2.
REQ-003 SHALL have clk, input, 1: the single clock; all state updates on posedge clk.
REQ-004 SHALL have rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have issue_valid, input, 1: upstream launches one operand into the fixed-latency pipe this cycle.
REQ-006 SHALL have issue_ready, output, 1: a launch is permitted this cycle.
REQ-007 SHALL have in_valid, input, 1: the pipe tail presents a result this cycle.
REQ-008 SHALL have in_data, input, BITWIDTH: the pipe tail result.
REQ-009 SHALL have out_valid, output, 1: buffer head is valid.
REQ-010 SHALL have out_ready, input, 1: the consumer accepts the head.
REQ-011 SHALL have out_data, output, BITWIDTH: the buffer head word.
REQ-012 SHALL have level, output, $clog2(DEPTH)+1: the stored entry count.
REQ-013 SHALL have err, output, 1: sticky protocol error flag.

Function
REQ-014 SHALL count an issue when issue_valid && issue_ready, a push when in_valid, and a pop when out_valid && out_ready.
REQ-015 SHALL keep inflight (width $clog2(DEPTH)+1): +1 per issue, -1 per push; both in one cycle leave it unchanged.
REQ-016 SHALL drive issue_ready = (level + inflight) < DEPTH, combinationally from registered state only, with no path from issue_valid.
REQ-017 SHALL ignore issue_valid while issue_ready is 0; inflight does not change.
REQ-018 SHALL write in_data at wr_ptr on a push; wr_ptr advances by 1 modulo DEPTH.
REQ-019 SHALL present out_data = mem[rd_ptr] first-word-fall-through; out_valid = (level != 0); rd_ptr advances by 1 modulo DEPTH on a pop.
REQ-020 SHALL make a word pushed in cycle N visible at out_valid/out_data in cycle N+1 when the buffer was empty: one cycle of latency, no bypass.
REQ-021 SHALL leave level unchanged on a simultaneous push and pop, including at level == DEPTH-1 and level == 1.
REQ-022 SHALL ignore out_ready while empty: no pointer or level change.
REQ-023 SHALL, on in_valid while level == DEPTH with no pop, drop the word and leave level and wr_ptr unchanged.
REQ-024 SHALL, on in_valid while inflight == 0, still store the word if space allows, and hold inflight at 0.
REQ-025 SHALL guarantee that credit accounting never allows level + inflight to exceed DEPTH under legal upstream behaviour.
REQ-026 SHALL hold out_data stable while out_valid && !out_ready.

Reset
REQ-027 SHALL, while rst is high, asynchronously force wr_ptr=0, rd_ptr=0, level=0, inflight=0, err=0, so out_valid=0 and issue_ready=1.
REQ-028 SHALL discard any words in flight at reset; in_valid during rst has no effect.
REQ-029 SHALL leave memory contents unreset; they are not observable while out_valid is 0.
REQ-030 SHALL make the first push allowed on the first posedge after rst deasserts.

Configuration
REQ-031 SHALL, with macro PIPE_DRAIN_BUFFER_ERR_CHECK_EN defined, set err to 1 on the REQ-023 overflow or the REQ-024 orphan push, and hold it until rst.
REQ-032 SHALL, without PIPE_DRAIN_BUFFER_ERR_CHECK_EN, tie err to 0 and synthesize no detection logic; the drop behaviour of REQ-023 is unchanged.

Verification
REQ-033 SHALL cover fill: DEPTH=8, 8 issues with in_valid 4 cycles later each, out_ready=0 -> issue_ready=0 after 8th issue, level=8, no err.
REQ-034 SHALL cover drain: then out_ready=1 for 8 cycles -> out_data 0..7 in order, level reaches 0, out_valid=0, issue_ready=1.
REQ-035 SHALL cover streaming: issue, push and pop every cycle, level=1 steady -> level constant, inflight constant, no data loss across 3 pointer wraps (24+ words).
REQ-036 SHALL cover overflow: macro defined, level=8, forced in_valid with data 0xAA -> word dropped, level stays 8, err=1 until rst.
REQ-037 SHALL cover reset mid-operation: level=5 and inflight=3 with rst pulsed asynchronously between edges -> out_valid=0, level=0, issue_ready=1 immediately, late in_valid after reset stored with err=1 when macro defined.
REQ-038 SHALL cover macro absent: REQ-036 stimulus -> err stays 0, word dropped.
